// File: rtl/regfile_ctx_engine.sv
`default_nettype none
// ============================================================================
// Module   : regfile_ctx_engine
// Purpose  : Context save/restore engine for a NUM_REGS x DATA_WIDTH register
//            file. Save drains every register, in index order, onto a
//            valid/ready output stream. Restore fills every register, in
//            index order, from a valid/ready input stream. While busy the
//            engine is the register file's only master.
// Ports    : clk, reset        - clock, synchronous active-high reset
//            start, mode       - begin operation (0 = save, 1 = restore)
//            abort             - terminate the current operation, no done
//            busy, done        - status; done is a one-cycle pulse
//            rf_readnum        - register-file read select (= idx)
//            rf_data_out       - register-file combinational read data
//            rf_writenum       - register-file write select (= idx)
//            rf_write          - register-file write enable
//            rf_data_in        - register-file write data (= in_data)
//            out_data, out_index, out_valid, out_ready - save stream
//            in_data, in_valid, in_ready               - restore stream
// Revision : 1.0 - initial release
// ============================================================================
module regfile_ctx_engine #(
  parameter  int DATA_WIDTH = 16,
  parameter  int NUM_REGS   = 8,
  localparam int IDX_W      = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  mode,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic [IDX_W-1:0]      rf_readnum,
  input  logic [DATA_WIDTH-1:0] rf_data_out,
  output logic [IDX_W-1:0]      rf_writenum,
  output logic                  rf_write,
  output logic [DATA_WIDTH-1:0] rf_data_in,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [IDX_W-1:0]      out_index,
  output logic                  out_valid,
  input  logic                  out_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SAVE_LD = 3'd1,
    S_SAVE_TX = 3'd2,
    S_RESTORE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic             last;

  assign last = (idx == LAST_IDX);

  // Status flags decode directly from the state register, so they are glitch
  // free and change only on clock edges.
  assign busy = (state == S_SAVE_LD) || (state == S_SAVE_TX) || (state == S_RESTORE);
  assign done = (state == S_DONE);

  // One index serves both directions; the register file sees it on both
  // selects at all times.
  assign rf_readnum  = idx;
  assign rf_writenum = idx;
  assign rf_data_in  = in_data;

  // abort gates in_ready combinationally so the register file is never
  // written in the cycle an operation is being torn down.
  assign in_ready = (state == S_RESTORE) && !abort;
  assign rf_write = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      idx       <= '0;
      out_data  <= '0;
      out_index <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            idx   <= '0;
            state <= mode ? S_RESTORE : S_SAVE_LD;
          end
        end

        S_SAVE_LD: begin
          if (abort) begin
            state     <= S_IDLE;
            idx       <= '0;
            out_valid <= 1'b0;
          end else begin
            out_data  <= rf_data_out;
            out_index <= idx;
            out_valid <= 1'b1;
            state     <= S_SAVE_TX;
          end
        end

        S_SAVE_TX: begin
          // A beat accepted in the abort cycle has already been delivered,
          // so abort simply takes precedence over the normal advance.
          if (abort) begin
            state     <= S_IDLE;
            idx       <= '0;
            out_valid <= 1'b0;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            if (last) begin
              state <= S_DONE;
            end else begin
              idx   <= idx + 1'b1;
              state <= S_SAVE_LD;
            end
          end
        end

        S_RESTORE: begin
          if (abort) begin
            state     <= S_IDLE;
            idx       <= '0;
            out_valid <= 1'b0;
          end else if (in_valid) begin
            // Handshake: the register file captures in_data on this edge.
            if (last) begin
              state <= S_DONE;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/regfile_ctx_engine.md
# regfile_ctx_engine

Context save/restore engine for the 8×16-bit register file. On command it drains every register, in index order, onto a valid/ready output stream (save), or fills every register from a valid/ready input stream (restore). It drives the register file's read select, write select, write enable and write data, and is the bus master toward the register file while busy.

## Interface
Parameters:
- DATA_WIDTH, 16, register and stream word width
- NUM_REGS, 8, registers transferred per operation; power of two ≥ 2; IDX_W = log2(NUM_REGS)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  begin an operation; sampled only in IDLE
- mode  in  1  0 = save, 1 = restore; sampled with start
- abort  in  1  terminate the current operation
- busy  out  1  high in SAVE_LD, SAVE_TX, RESTORE
- done  out  1  one-cycle pulse on normal completion
- rf_readnum  out  IDX_W  register-file read select
- rf_data_out  in  DATA_WIDTH  register-file combinational read data
- rf_writenum  out  IDX_W  register-file write select
- rf_write  out  1  register-file write enable
- rf_data_in  out  DATA_WIDTH  register-file write data
- out_data  out  DATA_WIDTH  save stream data (registered)
- out_index  out  IDX_W  register index of out_data
- out_valid  out  1  save stream valid (registered)
- out_ready  in  1  save stream ready
- in_data  in  DATA_WIDTH  restore stream data
- in_valid  in  1  restore stream valid
- in_ready  out  1  restore stream ready

## Operation
- States: IDLE, SAVE_LD, SAVE_TX, RESTORE, DONE. Internal index counter idx (IDX_W bits).
- IDLE: if start, then idx←0; mode=0 → SAVE_LD, mode=1 → RESTORE. start is ignored in every other state.
- rf_readnum = idx and rf_writenum = idx at all times. rf_data_in = in_data (combinational).
- SAVE_LD: out_data←rf_data_out, out_index←idx, out_valid←1; → SAVE_TX.
- SAVE_TX: out_valid stays high and out_data/out_index stay stable until out_valid&out_ready. On handshake, out_valid←0. If idx = NUM_REGS−1, → DONE; otherwise idx←idx+1 and → SAVE_LD.
- RESTORE: in_ready = !abort. rf_write = in_valid & in_ready (combinational), so the register file captures in_data at the same edge. On handshake: if idx = NUM_REGS−1, → DONE; otherwise idx←idx+1.
- DONE: done=1 and busy=0 for exactly one cycle; → IDLE.
- abort (in SAVE_LD, SAVE_TX or RESTORE): → IDLE next edge, out_valid←0, idx←0, no done pulse. A save beat accepted in the abort cycle counts as delivered. Abort gates in_ready, so no write occurs in the abort cycle. abort in IDLE or DONE has no effect.
- Reset at any time, including mid-operation: state IDLE, idx 0, out_data 0, out_index 0, out_valid 0, busy 0, done 0, in_ready 0, rf_write 0, rf_readnum 0, rf_writenum 0. Register-file contents are not touched.

## Timing
- Cycle 0 is the cycle in which start is sampled in IDLE.
- Save with out_ready held high: register r is in SAVE_LD at cycle 2r+1 and handshakes at cycle 2r+2. For NUM_REGS=8, the last beat is at cycle 16, done at cycle 17, and IDLE at cycle 18. Each stall cycle of out_ready adds one cycle.
- Restore with in_valid held high: register r is written at the edge ending cycle r+1. For NUM_REGS=8, done is at cycle 9. Each in_valid gap adds one cycle.
- Back-to-back operations: start may be reasserted at the cycle after DONE (IDLE).
- idx never wraps within an operation. DONE is entered instead of incrementing past NUM_REGS−1.

## Test plan
- Save, out_ready=1, registers preloaded R0..R7 = 16'h1000..16'h1007 → 8 beats with out_index 0..7 and data 16'h1000..16'h1007 at cycles 2,4,…,16; done at cycle 17; no rf_write.
- Save with out_ready low for 3 cycles on beat 4 → out_data stays 16'h1004 and out_valid stays high through the stall; done at cycle 20.
- Restore in_data=16'hA0A0+idx, in_valid=1 → rf_write high at cycles 1..8 with rf_writenum 0..7; a subsequent save returns 16'hA0A0..16'hA0A7.
- Restore with in_valid toggling 1,0,1,0… → exactly 8 writes, in order; done at cycle 16.
- Abort at restore beat 3 → R0..R2 updated, R3..R7 unchanged, no done, busy low next cycle; start ignored while busy.
- Reset asserted mid-save at cycle 7 → all outputs are at reset values the next cycle; a new save then completes normally.
